// File: rtl/fbuf_pixel_fetch_if.sv
// Pixel-fetch bus: timing in, RGB888 out, framebuffer write port and clear control.
// master = timing generator / CPU side, slave = fbuf_pixel_fetch.
interface fbuf_pixel_fetch_if #(
    parameter int ADDR_W = 17
);
    logic              in_vde;
    logic              in_hsync;
    logic              in_vsync;
    logic              in_eof;
    logic [ADDR_W-1:0] in_addr;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    logic              clr_start;
    logic [7:0]        clr_color;
    logic              clr_busy;

    logic              out_vde;
    logic              out_hsync;
    logic              out_vsync;
    logic [23:0]       out_rgb;

    modport master (
        output in_vde, in_hsync, in_vsync, in_eof, in_addr,
        output wr_valid, wr_addr, wr_data, clr_start, clr_color,
        input  wr_ready, clr_busy, out_vde, out_hsync, out_vsync, out_rgb
    );

    modport slave (
        input  in_vde, in_hsync, in_vsync, in_eof, in_addr,
        input  wr_valid, wr_addr, wr_data, clr_start, clr_color,
        output wr_ready, clr_busy, out_vde, out_hsync, out_vsync, out_rgb
    );
endinterface

// File: rtl/fbuf_pixel_fetch.sv
// RGB332 framebuffer reader -> RGB888 pixels aligned with delayed sync, plus write port and
// blanking-synchronised clear engine. Define FBUF_TESTPATTERN_EN to add tp_en colour bars.
module fbuf_pixel_fetch #(
    parameter int FBUF_DEPTH   = 129600,
    parameter int ADDR_W       = 17,
    parameter int READ_LATENCY = 2
) (
    input logic clk,
    input logic rst,
`ifdef FBUF_TESTPATTERN_EN
    input logic tp_en,
`endif
    fbuf_pixel_fetch_if.slave bus
);
    localparam int STAGES = READ_LATENCY + 1;
    localparam int IDX_W  = $clog2(FBUF_DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(FBUF_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(FBUF_DEPTH - 1);

    typedef struct packed {
        logic       vde;
        logic       hsync;
        logic       vsync;
        logic       ovr;
        logic [7:0] ovr_pix;
    } meta_t;

    typedef enum logic [1:0] {IDLE, ARMED, CLEAR} clr_state_t;

    function automatic logic [23:0] rgb332_to_888(input logic [7:0] p);
        return {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3], p[1:0], p[1:0], p[1:0], p[1:0]};
    endfunction

    logic in_oob, wr_oob;
    assign in_oob = bus.in_addr >= DEPTH_A;
    assign wr_oob = bus.wr_addr >= DEPTH_A;

    // Sideband travels with the read so out-of-range/pattern pixels override BRAM data in step.
    meta_t               meta_in;
    meta_t [STAGES:1]    vld_pipe;
    meta_t               rd_meta;

`ifdef FBUF_TESTPATTERN_EN
    logic [ADDR_W-1:0] tp_col;
    logic [2:0]        tp_bar;
    logic [7:0]        tp_pix;

    always_comb begin
        tp_pix = 8'h00;
        tp_col = bus.in_addr % ADDR_W'(480);
        tp_bar = 3'(tp_col / ADDR_W'(60));
        case (tp_bar)
            3'd0:    tp_pix = 8'hFF;
            3'd1:    tp_pix = 8'hFC;
            3'd2:    tp_pix = 8'h1F;
            3'd3:    tp_pix = 8'h1C;
            3'd4:    tp_pix = 8'hE3;
            3'd5:    tp_pix = 8'hE0;
            3'd6:    tp_pix = 8'h03;
            default: tp_pix = 8'h00;
        endcase
    end

    assign meta_in = {bus.in_vde, bus.in_hsync, bus.in_vsync, tp_en | in_oob,
                      tp_en ? tp_pix : 8'h00};
`else
    assign meta_in = {bus.in_vde, bus.in_hsync, bus.in_vsync, in_oob, 8'h00};
`endif

    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[STAGES-1:1], meta_in};
    end

    assign rd_meta = vld_pipe[READ_LATENCY];

    // Clear FSM
    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [7:0]        clr_color_q;
    logic              eof_q;
    logic              wr_ready_q;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            IDLE:  if (bus.clr_start) state_d = ARMED;
            ARMED: if (bus.in_eof && !eof_q) begin
                state_d    = CLEAR;
                clr_addr_d = '0;
            end
            CLEAR: if (clr_addr_q == LAST_A) state_d = IDLE;
                   else clr_addr_d = clr_addr_q + ADDR_W'(1);
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            clr_addr_q <= '0;
            eof_q      <= 1'b0;
            wr_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            eof_q      <= bus.in_eof;
            wr_ready_q <= state_d != CLEAR;
            if (state_q == IDLE && bus.clr_start) clr_color_q <= bus.clr_color;
        end
    end

    assign bus.wr_ready = wr_ready_q;
    assign bus.clr_busy = state_q != IDLE;

    // Framebuffer: clear engine owns the write port while running; reset cuts any write short.
    logic [7:0]       mem [FBUF_DEPTH];
    logic             mem_we;
    logic [IDX_W-1:0] mem_wa;
    logic [7:0]       mem_wd;
    logic             rd_en;
    logic [7:0]       ram_q;
    logic [7:0]       pix_d;

    always_comb begin
        mem_we = 1'b0;
        mem_wa = bus.wr_addr[IDX_W-1:0];
        mem_wd = bus.wr_data;
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_we = 1'b1;
                mem_wa = clr_addr_q[IDX_W-1:0];
                mem_wd = clr_color_q;
            end else if (bus.wr_valid && wr_ready_q && !wr_oob) begin
                mem_we = 1'b1;
            end
        end
    end

    assign rd_en = bus.in_vde && !in_oob;

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
        if (rd_en)  ram_q <= mem[bus.in_addr[IDX_W-1:0]];
    end

    generate
        if (READ_LATENCY == 2) begin : g_oreg
            logic [7:0] ram_q2;
            always_ff @(posedge clk) ram_q2 <= ram_q;
            assign pix_d = ram_q2;
        end else begin : g_noreg
            assign pix_d = ram_q;
        end
    endgenerate

    logic [7:0]  pix_sel;
    logic [23:0] out_rgb_q;

    assign pix_sel = rd_meta.ovr ? rd_meta.ovr_pix : pix_d;

    always_ff @(posedge clk) begin
        if (rst) out_rgb_q <= '0;
        else     out_rgb_q <= rd_meta.vde ? rgb332_to_888(pix_sel) : 24'h000000;
    end

    assign bus.out_rgb   = out_rgb_q;
    assign bus.out_vde   = vld_pipe[STAGES].vde;
    assign bus.out_hsync = vld_pipe[STAGES].hsync;
    assign bus.out_vsync = vld_pipe[STAGES].vsync;
endmodule

// File: tb/tb_fbuf_pixel_fetch.sv
// Scoreboard bench for fbuf_pixel_fetch: per-cycle expected outputs queued by the driver,
// compared by a monitor three cycles later. Small framebuffer keeps clear runs short.
module tb_fbuf_pixel_fetch;
    localparam int DEPTH = 1024;
    localparam int AW    = 17;
    localparam int L     = 3;

    typedef struct {
        int          due;
        logic        vde;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fbuf_pixel_fetch_if #(.ADDR_W(AW)) bus();

`ifdef FBUF_TESTPATTERN_EN
    logic tp_en = 1'b0;
`endif

    fbuf_pixel_fetch #(.FBUF_DEPTH(DEPTH), .ADDR_W(AW), .READ_LATENCY(2)) dut (
        .clk(clk),
        .rst(rst),
`ifdef FBUF_TESTPATTERN_EN
        .tp_en(tp_en),
`endif
        .bus(bus)
    );

    // Hand-expanded RGB332 -> RGB888 table used for all framebuffer contents.
    logic [7:0]  PV [8] = '{8'h00, 8'hFF, 8'hE0, 8'h1C, 8'h03, 8'h92, 8'h6D, 8'h49};
    logic [23:0] PR [8] = '{24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
                            24'h0000FF, 24'h9292AA, 24'h6D6D55, 24'h494955};

    logic [23:0] model [DEPTH];
    exp_t        sb [$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic        nxt_rst = 1'b0;
    logic        nxt_clr = 1'b0;
    logic [7:0]  nxt_col = 8'h00;
    bit          guard_wv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [23:0] exp_rd(input int vde, input int addr);
        if (vde == 0 || addr >= DEPTH) return 24'h000000;
        return model[addr];
    endfunction

    task automatic drive(input int vde, input int hs, input int vs, input int eof, input int addr,
                         input int wv, input int wa, input int widx, input logic [23:0] xrgb);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = nxt_rst;
        bus.clr_start = nxt_clr;
        bus.clr_color = nxt_col;
        nxt_clr       = 1'b0;
        bus.in_vde    = (vde != 0);
        bus.in_hsync  = (hs != 0);
        bus.in_vsync  = (vs != 0);
        bus.in_eof    = (eof != 0);
        bus.in_addr   = AW'(addr);
        bus.wr_valid  = guard_wv ? !bus.wr_ready : (wv != 0);
        bus.wr_addr   = AW'(wa);
        bus.wr_data   = PV[widx & 7];
        e.due = cyc + L;
        e.vde = bus.in_vde;
        e.hs  = bus.in_hsync;
        e.vs  = bus.in_vsync;
        e.rgb = xrgb;
        sb.push_back(e);
        if (bus.wr_valid && bus.wr_ready && wa < DEPTH) model[wa] = PR[widx & 7];
    endtask

    task automatic idle(input int eof, input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, eof, 0, 0, 0, 0, 24'h000000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        bit  done;

        bus.in_vde = 1'b0; bus.in_hsync = 1'b0; bus.in_vsync = 1'b0; bus.in_eof = 1'b0;
        bus.in_addr = '0; bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.clr_start = 1'b0; bus.clr_color = '0;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    e = sb.pop_front();
                    n_tests++;
                    if ({bus.out_vde, bus.out_hsync, bus.out_vsync, bus.out_rgb} !==
                        {e.vde, e.hs, e.vs, e.rgb}) begin
                        n_fail++;
                        $display("FAIL pix@%0d: got vde%b hs%b vs%b rgb %h expected vde%b hs%b vs%b rgb %h",
                                 cyc, bus.out_vde, bus.out_hsync, bus.out_vsync, bus.out_rgb,
                                 e.vde, e.hs, e.vs, e.rgb);
                    end
                end
            end
        join_none

        // Reset values
        @(posedge clk); #1;
        check("rst_wr_ready", 24'(bus.wr_ready), 24'd0);
        check("rst_clr_busy", 24'(bus.clr_busy), 24'd0);
        check("rst_out_vde", 24'(bus.out_vde), 24'd0);
        check("rst_out_rgb", bus.out_rgb, 24'h000000);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_wr_ready", 24'(bus.wr_ready), 24'd1);

        // Fill framebuffer with the table pattern
        for (int a = 0; a < DEPTH; a++) drive(0, 0, 0, 0, 0, 1, a, a % 8, 24'h000000);

        // Three small frames of timing; off-vde addresses are junk and must show black
        for (int f = 0; f < 3; f++)
            for (int ln = 0; ln < 6; ln++)
                for (int px = 0; px < 20; px++) begin
                    int v, ad;
                    v  = (ln < 4 && px < 16) ? 1 : 0;
                    ad = (v != 0) ? ln * 16 + px : 'h1F000 + px;
                    drive(v, (px >= 17 && px < 19) ? 1 : 0, (ln == 5) ? 1 : 0, (ln >= 4) ? 1 : 0,
                          ad, 0, 0, 0, exp_rd(v, ad));
                end

        // Directed writes/reads
        drive(0, 0, 0, 0, 0, 1, 5, 2, 24'h000000);
        drive(1, 0, 0, 0, 5, 0, 0, 0, 24'hFF0000);
        drive(1, 0, 0, 0, DEPTH + 1, 0, 0, 0, 24'h000000);
        drive(1, 0, 0, 0, 'h1FFFF, 0, 0, 0, 24'h000000);
        drive(1, 0, 0, 0, 12, 1, 12, 1, 24'h0000FF);
        drive(1, 0, 0, 0, 12, 0, 0, 0, 24'hFFFFFF);
        drive(0, 0, 0, 0, 0, 1, DEPTH, 1, 24'h000000);
        check("oob_wr_ready", 24'(bus.wr_ready), 24'd1);
        drive(0, 0, 0, 0, 0, 1, DEPTH + 2, 1, 24'h000000);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 24'h000000);
        drive(1, 0, 0, 0, 2, 0, 0, 0, 24'hFF0000);
        idle(0, 2);

        // Clear: armed mid-frame, writes still accepted until eof rises
        nxt_clr = 1'b1; nxt_col = 8'h1C;
        drive(0, 0, 0, 0, 0, 1, 20, 5, 24'h000000);
        check("start_wr_ready", 24'(bus.wr_ready), 24'd1);
        idle(0, 1);
        check("armed_busy", 24'(bus.clr_busy), 24'd1);
        check("armed_wr_ready", 24'(bus.wr_ready), 24'd1);
        nxt_clr = 1'b1; nxt_col = 8'hE0;
        drive(0, 0, 0, 0, 0, 1, 21, 6, 24'h000000);
        idle(0, 3);
        drive(1, 0, 0, 0, 20, 0, 0, 0, 24'h9292AA);
        drive(0, 0, 0, 1, 0, 1, 30, 1, 24'h000000);
        guard_wv = 1'b1;
        cnt = 0; done = 1'b0;
        for (int i = 0; i < DEPTH + 20 && !done; i++) begin
            drive(0, 0, 0, 1, 0, 1, 30, 1, 24'h000000);
            if (!bus.wr_ready) cnt++;
            if (!bus.clr_busy) done = 1'b1;
        end
        guard_wv = 1'b0;
        check("clear_done", 24'(done), 24'd1);
        check("clear_stall_cycles", 24'(cnt), 24'(DEPTH));
        check("clear_end_wr_ready", 24'(bus.wr_ready), 24'd1);
        for (int a = 0; a < DEPTH; a++) model[a] = 24'h00FF00;
        for (int a = 0; a < DEPTH; a++) drive(1, 0, 0, 1, a, 0, 0, 0, 24'h00FF00);

        // Reset while the clear is writing address 1000
        idle(0, 2);
        nxt_clr = 1'b1; nxt_col = 8'hE0;
        idle(0, 1);
        idle(0, 1);
        idle(1, 1);
        idle(1, 1000);
        nxt_rst = 1'b1;
        idle(1, 1);
        nxt_rst = 1'b0;
        idle(1, 1);
        check("midrst_busy", 24'(bus.clr_busy), 24'd0);
        check("midrst_wr_ready_hold", 24'(bus.wr_ready), 24'd0);
        idle(1, 1);
        check("midrst_wr_ready", 24'(bus.wr_ready), 24'd1);
        check("midrst_busy2", 24'(bus.clr_busy), 24'd0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 24'hFF0000);
        drive(1, 0, 0, 0, 999, 0, 0, 0, 24'hFF0000);
        drive(1, 0, 0, 0, 1001, 0, 0, 0, 24'h00FF00);
        drive(1, 0, 0, 0, 1023, 0, 0, 0, 24'h00FF00);
        idle(0, 1);

`ifdef FBUF_TESTPATTERN_EN
        tp_en = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 24'hFFFFFF);
        drive(1, 0, 0, 0, 60, 0, 0, 0, 24'hFFFF00);
        drive(1, 0, 0, 0, 120, 0, 0, 0, 24'h00FFFF);
        drive(1, 0, 0, 0, 479, 0, 0, 0, 24'h000000);
        drive(1, 0, 0, 0, 480 + 300, 0, 0, 0, 24'hFF0000);
        idle(0, 1);
        tp_en = 1'b0;
`endif

        idle(0, L + 2);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        check("sb_drained", 24'(sb.size()), 24'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
